pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazards:
  - load-use (inserts bubbles);
  - EX-resolved branch/jump redirect (squashes wrong-path instructions);
  - data-memory wait handshake (freezes the pipeline, with timeout).
- Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared codes for the pipeline hazard sequencer: next-PC selects, FSM states
// and the bundle of register enable/flush controls.
package pipe_hazard_ctrl_pkg;

    // Next-PC select codes produced by the EX stage
    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;

    // Sequencer states
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BUBBLE   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_flush;
    } ctrl_t;

    // Free-running pipeline
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    // Hold PC and IF/ID, push a bubble into EX, let the back end drain
    localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Squash the two wrong-path instructions behind a taken redirect
    localparam ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Whole pipeline frozen waiting for data memory
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Aborted access: drop the MEM result, advance only the back end
    localparam ctrl_t CTRL_ABORT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // Held in reset: nothing loads, everything is cleared
    localparam ctrl_t CTRL_RST    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM status in, pipeline register controls out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic [2:0]       ex_pcsrc;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline datapath side
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
               ex_pcsrc, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout, stall_cycles
    );

    // Hazard controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
               ex_pcsrc, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard classification for the current pipeline contents.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic [2:0] ex_pcsrc,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       lu,
    output logic       redir,
    output logic       mwait
);
    // $zero is never written, so a load targeting r0 cannot create a hazard
    always_comb begin
        lu    = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        redir = (ex_pcsrc != NPC_PLUS4);
        mwait = mem_req && !mem_ready;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirect
// squash, data-memory freeze with timeout, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0]      BUB_INIT = 2'(LU_BUBBLES - 1);

    logic              lu, redir, mwait;
    logic [1:0]        state_reg, state_next;
    logic [1:0]        bubble_cnt_reg, bubble_cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              ret_bubble_reg, ret_bubble_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              run_eval;
    ctrl_t             ctrl;

    hazard_detect u_detect (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .ex_pcsrc    (bus.ex_pcsrc),
        .mem_req     (bus.mem_req),
        .mem_ready   (bus.mem_ready),
        .lu          (lu),
        .redir       (redir),
        .mwait       (mwait)
    );

    // Output controls and next state from the current state and hazards
    always_comb begin
        ctrl            = CTRL_RUN;
        state_next      = state_reg;
        bubble_cnt_next = bubble_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        ret_bubble_next = ret_bubble_reg;
        timeout_next    = 1'b0;
        run_eval        = 1'b0;
        case (state_reg)
            ST_BUBBLE: begin
                if (mwait) begin
                    // Freeze wins; bubble count is held for the return trip
                    ctrl            = CTRL_FREEZE;
                    state_next      = ST_MEM_WAIT;
                    wait_cnt_next   = WAIT_W'(1);
                    ret_bubble_next = 1'b1;
                end else begin
                    ctrl = CTRL_LU;
                    if (bubble_cnt_reg == 2'd1) begin
                        state_next = ST_RUN;
                    end else begin
                        bubble_cnt_next = bubble_cnt_reg - 2'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // A dropped request counts as completion
                if (!bus.mem_req || bus.mem_ready) begin
                    state_next      = ret_bubble_reg ? ST_BUBBLE : ST_RUN;
                    run_eval        = !ret_bubble_reg;
                    ret_bubble_next = 1'b0;
                    wait_cnt_next   = '0;
                end else if (wait_cnt_reg == WAIT_MAX) begin
                    ctrl            = CTRL_ABORT;
                    state_next      = ST_RUN;
                    ret_bubble_next = 1'b0;
                    wait_cnt_next   = '0;
                    timeout_next    = 1'b1;
                end else begin
                    ctrl          = CTRL_FREEZE;
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            default: run_eval = 1'b1;
        endcase

        // RUN-state priority: memory wait, then redirect, then load-use
        if (run_eval) begin
            if (mwait) begin
                ctrl            = CTRL_FREEZE;
                state_next      = ST_MEM_WAIT;
                wait_cnt_next   = WAIT_W'(1);
                ret_bubble_next = 1'b0;
            end else if (redir) begin
                ctrl = CTRL_REDIR;
            end else if (lu) begin
                ctrl = CTRL_LU;
                if (LU_BUBBLES > 1) begin
                    state_next      = ST_BUBBLE;
                    bubble_cnt_next = BUB_INIT;
                end
            end
        end

        if (rst) begin
            ctrl = CTRL_RST;
        end
    end

    // Sequencer state and the registered timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            bubble_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            ret_bubble_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bubble_cnt_reg <= bubble_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            ret_bubble_reg <= ret_bubble_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Count cycles with the PC held, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (!ctrl.pc_en && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.mem_timeout  = timeout_reg;
    assign bus.stall_cycles = stall_cnt_reg;
endmodule
